data_mem_mmio: RTL and testbench

- Responder for the CPU data-memory port. It serves the MEM-stage access (address, mem_read, mem_write, byte, store data) and returns load data in the same cycle.
- It contains a word-addressed data RAM and a small MMIO console block.
- The console block holds a TX byte FIFO that a downstream consumer (UART model or testbench) drains through a valid/ready handshake.
- It is a drop-in replacement for the plain data memory in the cpu top level.

---
 rtl/data_mem_mmio.sv | 149 ++++++++++++++
 tb/tb_data_mem_mmio.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem_mmio.sv
// rtl/data_mem_mmio.sv - CPU data-memory responder: word RAM plus MMIO console TX FIFO
// Loads are combinational; stores, FIFO push/pop and the sticky error flag update on the rising edge.
module data_mem_mmio #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] DATA_BASE   = 32'h0000_0000,
    parameter logic [31:0] MMIO_BASE   = 32'h0000_7F00,
    parameter int          FIFO_DEPTH  = 8
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [31:0] i_addr,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic        i_byte,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_tx_valid,
    output logic [7:0]  o_tx_data,
    input  logic        i_tx_ready,
    output logic        o_bus_error
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   r_ram  [DEPTH_WORDS];
    logic [7:0]    r_fifo [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic          r_bus_error;

    logic [29:0]   w_word_off;
    logic          w_ram_hit;
    logic [AW-1:0] w_ram_idx;
    logic          w_mmio_hit;
    logic [1:0]    w_lane;
    logic [1:0]    w_reg;
    logic          w_access;
    logic          w_misaligned;
    logic          w_illegal;
    logic          w_ram_sel;
    logic          w_mmio_sel;
    logic          w_ram_we;
    logic          w_push_req;
    logic          w_ovf_clr;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push;
    logic [7:0]    w_count8;
    logic [31:0]   w_status;
    logic [31:0]   w_ram_word;

    // Word-granular offset keeps the range check free of a 33-bit add.
    assign w_word_off   = i_addr[31:2] - DATA_BASE[31:2];
    assign w_ram_hit    = (i_addr[31:2] >= DATA_BASE[31:2]) && (w_word_off[29:AW] == '0);
    assign w_ram_idx    = w_word_off[AW-1:0];
    assign w_mmio_hit   = (i_addr[31:4] == MMIO_BASE[31:4]);
    assign w_lane       = i_addr[1:0];
    assign w_reg        = i_addr[3:2];

    assign w_access     = i_mem_read || i_mem_write;
    assign w_misaligned = !i_byte && (i_addr[1:0] != 2'b00);
    assign w_illegal    = w_access && (!(w_ram_hit || w_mmio_hit) || w_misaligned
                                       || (w_mmio_hit && i_byte));
    assign w_ram_sel    = w_ram_hit && !w_mmio_hit && !w_illegal;
    assign w_mmio_sel   = w_mmio_hit && !w_illegal;

    assign w_ram_we     = w_ram_sel && i_mem_write;
    assign w_push_req   = w_mmio_sel && i_mem_write && (w_reg == 2'd1);
    assign w_ovf_clr    = w_mmio_sel && i_mem_write && (w_reg == 2'd2) && i_wdata[0];

    assign w_full       = (r_count == CW'(FIFO_DEPTH));
    assign w_empty      = (r_count == '0);
    assign w_pop        = !w_empty && i_tx_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push       = w_push_req && (!w_full || w_pop);

    assign w_count8     = 8'(r_count);
    assign w_status     = {16'h0000, w_count8, 5'b00000, r_overflow, w_empty, w_full};
    assign w_ram_word   = r_ram[w_ram_idx];

    always_comb begin
        o_rdata = '0;
        if (i_mem_read && w_ram_sel) begin
            if (i_byte) begin
                o_rdata = {24'h000000, w_ram_word[{w_lane, 3'b000} +: 8]};
            end else begin
                o_rdata = w_ram_word;
            end
        end else if (i_mem_read && w_mmio_sel && (w_reg == 2'd0)) begin
            o_rdata = w_status;
        end
    end

    always_ff @(posedge i_clock) begin
        if (w_ram_we) begin
            if (i_byte) begin
                r_ram[w_ram_idx][{w_lane, 3'b000} +: 8] <= i_wdata[7:0];
            end else begin
                r_ram[w_ram_idx] <= i_wdata;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= i_wdata[7:0];
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_bus_error <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_push_req && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end else if (w_ovf_clr) begin
                r_overflow <= 1'b0;
            end
            if (w_illegal) begin
                r_bus_error <= 1'b1;
            end
        end
    end

    assign o_tx_valid  = !w_empty;
    assign o_tx_data   = w_empty ? 8'h00 : r_fifo[r_rd_ptr];
    assign o_bus_error = r_bus_error;

endmodule

// File: tb/tb_data_mem_mmio.sv
// tb/tb_data_mem_mmio.sv - scoreboard bench for data_mem_mmio: RAM paths, console FIFO, errors, reset
module tb_data_mem_mmio;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic        byte_acc = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic        bus_error;

    int n_checks = 0;
    int n_errors = 0;
    int m_cnt = 0;
    logic [31:0] q_rd [$];
    logic [7:0]  q_tx [$];
    logic [7:0]  msg [8] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h21, 8'h0A, 8'h58};

    data_mem_mmio dut (
        .i_clock     (clock),
        .i_reset     (reset),
        .i_addr      (addr),
        .i_mem_read  (mem_read),
        .i_mem_write (mem_write),
        .i_byte      (byte_acc),
        .i_wdata     (wdata),
        .o_rdata     (rdata),
        .o_tx_valid  (tx_valid),
        .o_tx_data   (tx_data),
        .i_tx_ready  (tx_ready),
        .o_bus_error (bus_error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Consumer side: every accepted byte must be the oldest one still expected.
    always @(negedge clock) begin
        if (reset && tx_valid && tx_ready) begin
            if (q_tx.size() > 0) begin
                chk("tx_data", 32'(tx_data), 32'(q_tx.pop_front()));
                m_cnt--;
            end else begin
                chk("tx_extra", 32'(tx_valid), 32'h0);
            end
        end
    end

    task automatic bus_op(input logic rd, input logic wr, input logic bt, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp, input string tag);
        @(posedge clock);
        #1;
        mem_read  = rd;
        mem_write = wr;
        byte_acc  = bt;
        addr      = a;
        wdata     = d;
        if (rd) q_rd.push_back(exp);
        @(negedge clock);
        if (rd) chk(tag, rdata, q_rd.pop_front());
        else    chk({tag, "_rd0"}, rdata, 32'h0);
    endtask

    task automatic idle();
        @(posedge clock);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        byte_acc  = 1'b0;
    endtask

    task automatic tx_push(input logic [7:0] b);
        if (m_cnt < 8) begin
            q_tx.push_back(b);
            m_cnt++;
        end
        bus_op(1'b0, 1'b1, 1'b0, 32'h7F04, {24'h0, b}, 32'h0, "tx_push");
    endtask

    task automatic drain(input int n);
        @(posedge clock);
        #1;
        tx_ready = 1'b1;
        repeat (n) @(posedge clock);
        #1;
        tx_ready = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clock);
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        chk("rst_bus_error", 32'(bus_error), 32'h0);
        reset = 1'b1;
        bus_op(1'b1, 1'b0, 1'b0, 32'h7F00, 32'h0, 32'h0000_0002, "status_after_rst");

        bus_op(1'b0, 1'b1, 1'b0, 32'h10, 32'hA1B2C3D4, 32'h0, "sw10");
        bus_op(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'hA1B2C3D4, "lw10");
        bus_op(1'b1, 1'b0, 1'b1, 32'h11, 32'h0, 32'h0000_00C3, "lbu11");
        bus_op(1'b0, 1'b1, 1'b1, 32'h13, 32'h0000_005E, 32'h0, "sb13");
        bus_op(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h5EB2C3D4, "lw10_after_sb");
        bus_op(1'b1, 1'b0, 1'b1, 32'h13, 32'h0, 32'h0000_005E, "lbu13");

        bus_op(1'b0, 1'b1, 1'b0, 32'h20, 32'h11111111, 32'h0, "sw20");
        bus_op(1'b1, 1'b1, 1'b0, 32'h20, 32'h22222222, 32'h11111111, "rw20_old");
        bus_op(1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 32'h22222222, "lw20_new");
        bus_op(1'b0, 1'b1, 1'b0, 32'h0, 32'hCAFEF00D, 32'h0, "sw0");

        foreach (msg[i]) tx_push(msg[i]);
        bus_op(1'b1, 1'b0, 1'b0, 32'h7F00, 32'h0, 32'h0000_0801, "status_full");
        chk("tx_head_stable", 32'(tx_data), 32'h48);
        tx_push(8'h5A);
        bus_op(1'b1, 1'b0, 1'b0, 32'h7F00, 32'h0, 32'h0000_0805, "status_overflow");
        bus_op(1'b0, 1'b1, 1'b0, 32'h7F08, 32'h1, 32'h0, "ctrl_clear");
        bus_op(1'b1, 1'b0, 1'b0, 32'h7F00, 32'h0, 32'h0000_0801, "status_ovf_cleared");
        bus_op(1'b1, 1'b0, 1'b0, 32'h7F04, 32'h0, 32'h0, "rd_txdata");
        bus_op(1'b1, 1'b0, 1'b0, 32'h7F0C, 32'h0, 32'h0, "rd_reserved");
        bus_op(1'b0, 1'b1, 1'b0, 32'h7F00, 32'hFFFF_FFFF, 32'h0, "wr_status");
        idle();

        drain(8);
        @(negedge clock);
        chk("drained_valid", 32'(tx_valid), 32'h0);
        chk("drained_scoreboard", 32'(q_tx.size()), 32'h0);
        bus_op(1'b1, 1'b0, 1'b0, 32'h7F00, 32'h0, 32'h0000_0002, "status_empty");

        for (int i = 0; i < 8; i++) tx_push(8'(8'h30 + i));
        @(posedge clock);
        #1;
        tx_ready  = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b1;
        byte_acc  = 1'b0;
        addr      = 32'h7F04;
        wdata     = 32'h39;
        q_tx.push_back(8'h39);
        m_cnt++;
        @(negedge clock);
        @(posedge clock);
        #1;
        tx_ready  = 1'b0;
        mem_write = 1'b0;
        bus_op(1'b1, 1'b0, 1'b0, 32'h7F00, 32'h0, 32'h0000_0801, "status_push_pop_full");
        idle();
        drain(8);
        @(negedge clock);
        chk("drained2_scoreboard", 32'(q_tx.size()), 32'h0);
        chk("bus_error_clean", 32'(bus_error), 32'h0);

        bus_op(1'b1, 1'b0, 1'b0, 32'h12, 32'h0, 32'h0, "lw_misaligned");
        chk("bus_error_not_yet", 32'(bus_error), 32'h0);
        idle();
        @(negedge clock);
        chk("bus_error_set", 32'(bus_error), 32'h1);
        bus_op(1'b0, 1'b1, 1'b0, 32'h9000, 32'hDEADBEEF, 32'h0, "sw_unmapped");
        bus_op(1'b0, 1'b1, 1'b0, 32'h1010, 32'hDEADBEEF, 32'h0, "sw_past_ram");
        bus_op(1'b1, 1'b0, 1'b1, 32'h7F00, 32'h0, 32'h0, "lbu_mmio");
        bus_op(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'hCAFEF00D, "lw0_intact");
        bus_op(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h5EB2C3D4, "lw10_intact");
        repeat (5) idle();
        @(negedge clock);
        chk("bus_error_sticky", 32'(bus_error), 32'h1);

        for (int i = 0; i < 3; i++) tx_push(8'(8'h41 + i));
        idle();
        @(negedge clock);
        chk("queued_valid", 32'(tx_valid), 32'h1);
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        chk("async_tx_valid", 32'(tx_valid), 32'h0);
        chk("async_bus_error", 32'(bus_error), 32'h0);
        q_tx.delete();
        m_cnt = 0;
        @(negedge clock);
        #1;
        reset = 1'b1;
        bus_op(1'b1, 1'b0, 1'b0, 32'h7F00, 32'h0, 32'h0000_0002, "status_post_reset");
        bus_op(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h5EB2C3D4, "lw10_post_reset");
        idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
